// File: rtl/maxpool_2x2.sv
// maxpool_2x2: streaming 2x2 / stride-2 signed max-pool over a raster feature map; MAXPOOL_RELU_EN fuses ReLU.
// Latency: oValid 1 cycle after a window's bottom-right sample. No back-pressure: every oValid must be taken.
module maxpool_2x2 #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic signed [DATA_W-1:0] iX,
  input  logic                     iValid,
  output logic signed [DATA_W-1:0] oY,
  output logic                     oValid,
  output logic                     oFrameDone
);
  localparam int LB_N = IMG_W / 2;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int IW   = (LB_N > 1) ? $clog2(LB_N) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic signed [DATA_W-1:0] hold;
  logic signed [DATA_W-1:0] lbuf [LB_N];
  logic [IW-1:0]            lb_idx;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] win_max;
  logic signed [DATA_W-1:0] pooled;
  logic                     col_last;
  logic                     row_last;
  logic                     skip_col;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  // An even last column only exists for odd widths; it has no partner and is dropped.
  assign skip_col = col_last && !col[0];
  assign lb_idx   = IW'(col >> 1);

  always_comb begin
    pair_max = smax(hold, iX);
    win_max  = smax(pair_max, lbuf[lb_idx]);
  end

`ifdef MAXPOOL_RELU_EN
  assign pooled = win_max[DATA_W-1] ? '0 : win_max;
`else
  assign pooled = win_max;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      oY         <= '0;
      oValid     <= 1'b0;
      oFrameDone <= 1'b0;
    end else begin
      oValid     <= iValid && row[0] && col[0];
      oFrameDone <= iValid && row_last && col_last;
      if (iValid) begin
        if (!col[0] && !skip_col) begin
          hold <= iX;
        end
        if (row[0] && col[0]) begin
          oY <= pooled;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Line buffer needs no reset: every entry is written on an even row before the odd row reads it.
  always_ff @(posedge iCLK) begin
    if (iValid && !iRST && !row[0] && col[0]) begin
      lbuf[lb_idx] <= pair_max;
    end
  end
endmodule

// File: doc/maxpool_2x2.md
Name: maxpool_2x2

Overview:
- Streaming 2x2, stride-2 max-pooling stage directly downstream of the 5x5 convolution block.
- Consumes the saturated convolution output stream (oY/oValid of the conv stage) in row-major raster order.
- Emits one pooled value per 2x2 window.
- A half-row line buffer holds the pairwise maxima of even rows, so each window completes on the odd row.

Parameters:
- DATA_W, 32, signed sample width
- IMG_W, 28, feature-map width in samples (conv output width)
- IMG_H, 28, feature-map height in rows

Ports:
- iCLK  input  1  clock; all state updates on rising edge
- iRST  input  1  asynchronous, active-high reset
- iX  input  DATA_W  signed input sample (conv oY)
- iValid  input  1  iX valid this cycle (conv oValid)
- oY  output  DATA_W  signed pooled result
- oValid  output  1  oY valid, single-cycle pulse per window
- oFrameDone  output  1  single-cycle pulse after the last sample of a frame

Behaviour:
- Reset (async, iRST=1): oY=0, oValid=0, oFrameDone=0, column counter=0, row counter=0, hold register=0. Line buffer is not cleared; it is always written on an even row before being read.
- Counters advance only on cycles with iValid=1. Idle cycles (iValid=0) preserve all state; there is no timeout.
- col runs 0..IMG_W-1, then wraps to 0 and row increments. row runs 0..IMG_H-1, then wraps to 0 (next frame).
- Even row, even col: hold <= iX.
- Even row, odd col: lbuf[col>>1] <= max(hold, iX).
- Odd row, even col: hold <= iX.
- Odd row, odd col: oY <= max(hold, iX, lbuf[col>>1]); oValid=1 in the next cycle.
- All comparisons are signed two's complement, DATA_W bits. Ties resolve to an equal value; no width growth.
- Latency: oValid rises exactly 1 cycle after the 4th (bottom-right) sample of a window is accepted.
- oY holds its last value while oValid=0.
- Odd IMG_W: last column is ignored and never stored.
- Odd IMG_H: last row is consumed as an even row (writes lbuf) and produces no output.
- Output count per frame: floor(IMG_W/2)*floor(IMG_H/2).
- oFrameDone: pulses 1 cycle after acceptance of the sample at (IMG_H-1, IMG_W-1). It coincides with the final oValid when both dimensions are even.
- Back-to-back frames with no gap are supported: the counter wrap and a first-row sample are handled in consecutive cycles without stalls.
- No back-pressure: the downstream stage must accept every oValid pulse.
- Line buffer: floor(IMG_W/2) registers of DATA_W bits, indexed by col>>1.
- Reset mid-frame: counters and outputs return to the reset state immediately. Partial-window data is discarded, no spurious oValid follows, and the next accepted sample is treated as (0,0).

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined: fused ReLU. The registered oY equals the window max when that max is >= 0, otherwise 0. Timing and oValid are unchanged.
- Undefined: oY is the raw signed window max; negative results pass through.

Test Plan:
- IMG_W=4, IMG_H=4; feed 0..15 row-major, iValid continuous -> oY = 5, 7, 13, 15 on 4 oValid pulses; oFrameDone 1 cycle after sample 15.
- IMG_W=4, IMG_H=4; all samples -5 except -1 at (1,2) -> oY = -5, -1, -5, -5 (signed compare; with MAXPOOL_RELU_EN: 0, 0, 0, 0).
- Same data as test 1 with iValid toggled pseudo-randomly (about 50% duty) -> identical oY sequence; each oValid lands 1 cycle after the completing accepted sample.
- IMG_W=5, IMG_H=5; feed 0..24 -> exactly 4 outputs: 6, 8, 16, 18; oFrameDone after sample 24; column 4 and row 4 are never output.
- IMG_W=4, IMG_H=4; assert iRST after 6 samples, release, then feed a full 0..15 frame -> no oValid before the new frame's sample 5; outputs 5, 7, 13, 15.
- Two frames back-to-back, 0..15 then 100..115 -> outputs 5, 7, 13, 15, 105, 107, 113, 115; two oFrameDone pulses.
